line_refill_engine: RTL and testbench
=====================================

# line_refill_engine

Memory-side line mover sitting directly downstream of the cache control FSM. On a read or write miss the FSM hands over the victim line (and its dirty flag) plus the missing line address. This block writes the victim back to main memory word-by-word if dirty, then fetches the new line. It returns the refilled line with a one-cycle done pulse, so the FSM can complete its EVICT step and install the line in the selected way.

## Interface
- ADDR_W, 32, byte-address width.
- WORD_W, 32, data word width; multiple of 8.
- WORDS, 4, words per cache line; power of two, at least 2.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  1  miss-service request from cache FSM; level, held until done.
- victim_dirty  in  1  victim line must be written back.
- victim_addr  in  ADDR_W  byte address of victim line.
- victim_data  in  WORDS*WORD_W  victim line; word 0 in LSBs.
- fill_addr  in  ADDR_W  byte address of missing line.
- busy  out  1  high from request acceptance until done cycle inclusive.
- done  out  1  one-cycle pulse; fill_data valid in this cycle.
- fill_data  out  WORDS*WORD_W  refilled line; word 0 in LSBs.
- mem_req  out  1  word transfer request to main memory.
- mem_we  out  1  1 = write (write-back), 0 = read (fill).
- mem_addr  out  ADDR_W  word byte address.
- mem_wdata  out  WORD_W  write word.
- mem_ack  in  1  memory completes current word this cycle.
- mem_rdata  in  WORD_W  read word; valid when mem_ack and !mem_we.

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: when req=1, latch victim_dirty, victim_addr, victim_data, fill_addr. Go to WB if dirty, else FILL. Clear word counter. busy=1 from the next cycle.
- Line alignment: low log2(WORDS*WORD_W/8) bits of both latched addresses are forced to 0.
- Word address is base + idx*(WORD_W/8), ADDR_W-bit modulo arithmetic. Wrap at the top of the address space is silent.
- WB: mem_req=1, mem_we=1, mem_wdata = latched word idx. On mem_ack, idx increments. The ack of the last word (idx = WORDS-1) clears idx and moves to FILL.
- FILL: mem_req=1, mem_we=0. On mem_ack, mem_rdata is stored into fill_data word idx and idx increments. The ack of the last word moves to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- fill_data holds its value until the next FILL overwrites it word by word.
- Requests are never queued:
  - req is only sampled in IDLE.
  - req still high in the IDLE cycle after DONE is taken as a new request. The FSM must drop req on done.
- mem_ack while mem_req=0 is ignored.
- Inputs other than req are don't-care outside the IDLE acceptance cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, fill_data 0, idx 0.
- All outputs are registered.
- Reset mid-transfer:
  - abandons the line immediately (asynchronous);
  - mem_req drops without waiting for mem_ack;
  - no done is produced.
- mem_req, mem_we, mem_addr and mem_wdata are stable while mem_req=1 and mem_ack=0.
- After an ack, the next word's address and data appear the following cycle with mem_req still high. Back-to-back acks therefore give one word per cycle.
- Clean miss, ack tied high: req sampled at edge E0; word acks at E1..E<WORDS>; done high in the cycle after E<WORDS>. Request-to-done is WORDS+1 cycles (5 at defaults).
- Dirty miss, ack tied high: 2*WORDS+1 cycles (9 at defaults). There is no bubble between the last write and the first read.
- Each memory stall cycle (mem_ack=0 with mem_req=1) adds exactly one cycle.

## Test plan
- Clean miss: fill_addr=0x0000_1234, mem_ack always 1, memory returns word = address. Expect:
  - reads at 0x1230, 0x1234, 0x1238, 0x123C with mem_we=0;
  - done 5 cycles after req;
  - fill_data = {0x123C, 0x1238, 0x1234, 0x1230}.
- Dirty miss: victim_addr=0x40, victim_data words A0..A3, fill_addr=0x80. Expect:
  - writes A0..A3 at 0x40..0x4C;
  - then reads at 0x80..0x8C;
  - done 9 cycles after req.
- Stalls: mem_ack low for 3 cycles before each word on a clean miss. Expect address held stable during each stall, and done 17 cycles after req.
- Request while busy: toggle req mid-FILL and change fill_addr. Expect no effect on the current transfer. After done, req=1 in IDLE starts a new line.
- Reset mid-WB: assert rst after the 2nd write ack. Expect:
  - mem_req and busy 0 in the same cycle;
  - no done;
  - fill_data=0;
  - the next request starts at word 0.
- Address wrap: fill_addr=0xFFFF_FFF4 (clean). Expect reads at 0xFFFF_FFF0..0xFFFF_FFFC and normal done.

Source files
------------

// File: rtl/line_refill_engine.sv
// line_refill_engine: writes back a dirty victim line word by word, then fetches
// the missing line from main memory and returns it with a one-cycle done pulse.
module line_refill_engine #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int WORDS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   input  logic                    victim_dirty,
   input  logic [ADDR_W-1:0]       victim_addr,
   input  logic [WORDS*WORD_W-1:0] victim_data,
   input  logic [ADDR_W-1:0]       fill_addr,
   output logic                    busy,
   output logic                    done,
   output logic [WORDS*WORD_W-1:0] fill_data,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [WORD_W-1:0]       mem_wdata,
   input  logic                    mem_ack,
   input  logic [WORD_W-1:0]       mem_rdata
);
   localparam int IDX_W      = $clog2(WORDS);
   localparam int WORD_BYTES = WORD_W / 8;
   localparam int LINE_BYTES = WORDS * WORD_BYTES;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_next;
   logic              last;
   logic [ADDR_W-1:0] victim_base;
   logic [ADDR_W-1:0] fill_base;
   logic [WORD_W-1:0] victim_in    [WORDS];
   logic [WORD_W-1:0] victim_words [WORDS];
   logic [WORD_W-1:0] fill_words   [WORDS];

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  i);
      return base + ADDR_W'(i) * ADDR_W'(WORD_BYTES);
   endfunction

   for (genvar g = 0; g < WORDS; g++) begin : g_words
      assign victim_in[g]                    = victim_data[g*WORD_W +: WORD_W];
      assign fill_data[g*WORD_W +: WORD_W]   = fill_words[g];
   end

   assign idx_next = idx + IDX_W'(1);
   assign last     = (idx == IDX_W'(WORDS - 1));

   // Address/data of the next word are loaded on the ack itself, so the bus
   // presents a new word the cycle after every ack without a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         victim_base  <= '0;
         fill_base    <= '0;
         victim_words <= '{default: '0};
         fill_words   <= '{default: '0};
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  victim_base  <= victim_addr & LINE_MASK;
                  fill_base    <= fill_addr & LINE_MASK;
                  victim_words <= victim_in;
                  idx          <= '0;
                  busy         <= 1'b1;
                  mem_req      <= 1'b1;
                  mem_we       <= victim_dirty;
                  mem_addr     <= victim_dirty ? (victim_addr & LINE_MASK)
                                               : (fill_addr & LINE_MASK);
                  mem_wdata    <= victim_in[0];
                  state        <= victim_dirty ? WB : FILL;
               end
            end
            WB: begin
               if (mem_ack) begin
                  if (last) begin
                     idx      <= '0;
                     mem_we   <= 1'b0;
                     mem_addr <= fill_base;
                     state    <= FILL;
                  end else begin
                     idx       <= idx_next;
                     mem_addr  <= word_addr(victim_base, idx_next);
                     mem_wdata <= victim_words[idx_next];
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  fill_words[idx] <= mem_rdata;
                  if (last) begin
                     mem_req <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     idx      <= idx_next;
                     mem_addr <= word_addr(fill_base, idx_next);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               idx   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_refill_engine.sv
// tb_line_refill_engine: randomized line moves against a transaction-list model
// of write-back + fill, with a word-addressed memory returning addr ^ key.
module tb_line_refill_engine;
   localparam int ADDR_W     = 32;
   localparam int WORD_W     = 32;
   localparam int WORDS      = 4;
   localparam int LW         = WORDS * WORD_W;
   localparam int WORD_BYTES = WORD_W / 8;
   localparam int LINE_BYTES = WORDS * WORD_BYTES;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req = 1'b0;
   logic              victim_dirty = 1'b0;
   logic [ADDR_W-1:0] victim_addr = '0;
   logic [LW-1:0]     victim_data = '0;
   logic [ADDR_W-1:0] fill_addr = '0;
   logic              busy, done, mem_req, mem_we;
   logic [LW-1:0]     fill_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_ack = 1'b0;
   logic [WORD_W-1:0] mem_rdata = '0;

   line_refill_engine #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .req(req), .victim_dirty(victim_dirty),
      .victim_addr(victim_addr), .victim_data(victim_data), .fill_addr(fill_addr),
      .busy(busy), .done(done), .fill_data(fill_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [ADDR_W-1:0] tx_addr[$], exp_addr[$];
   logic              tx_we[$],   exp_we[$];
   logic [WORD_W-1:0] tx_wd[$],   exp_wd[$];
   logic [LW-1:0]     got_fill, exp_fill;
   logic [WORD_W-1:0] key;
   int                lat, exp_lat, stall_total, stab_err;

   // Reference model: the list of word transfers a miss must produce and the line it returns.
   task automatic build_expect(input bit dirty, input logic [ADDR_W-1:0] va,
                               input logic [LW-1:0] vd, input logic [ADDR_W-1:0] fa);
      logic [ADDR_W-1:0] vb, fb, a;
      vb = va & ~ADDR_W'(LINE_BYTES - 1);
      fb = fa & ~ADDR_W'(LINE_BYTES - 1);
      exp_addr.delete(); exp_we.delete(); exp_wd.delete();
      if (dirty) begin
         for (int i = 0; i < WORDS; i++) begin
            exp_we.push_back(1'b1);
            exp_addr.push_back(vb + ADDR_W'(i * WORD_BYTES));
            exp_wd.push_back(vd[i*WORD_W +: WORD_W]);
         end
      end
      for (int i = 0; i < WORDS; i++) begin
         a = fb + ADDR_W'(i * WORD_BYTES);
         exp_we.push_back(1'b0);
         exp_addr.push_back(a);
         exp_wd.push_back('0);
         exp_fill[i*WORD_W +: WORD_W] = WORD_W'(a) ^ key;
      end
      exp_lat = 1 + (dirty ? 2 * WORDS : WORDS);
   endtask

   function automatic int tx_diff();
      if (tx_addr.size() != exp_addr.size())
         return (tx_addr.size() < exp_addr.size()) ? tx_addr.size() : exp_addr.size();
      foreach (exp_addr[i])
         if (tx_we[i] !== exp_we[i] || tx_addr[i] !== exp_addr[i] || tx_wd[i] !== exp_wd[i])
            return i;
      return -1;
   endfunction

   // Drives one miss and acts as memory; records transfers, latency and stall stability.
   task automatic run_line(input bit dirty, input logic [ADDR_W-1:0] va, input logic [LW-1:0] vd,
                           input logic [ADDR_W-1:0] fa, input int smin, input int smax,
                           input bit toggle, input bit keep_req, input bit wait_idle);
      int n, stall_left;
      bit new_word;
      logic [ADDR_W-1:0] h_addr;
      logic              h_we;
      logic [WORD_W-1:0] h_wd;
      tx_addr.delete(); tx_we.delete(); tx_wd.delete();
      stall_total = 0; stab_err = 0; lat = -1; stall_left = 0;
      if (wait_idle)
         for (int k = 0; k < 20 && busy; k++) begin @(posedge clk); #1; end
      req = 1'b1; victim_dirty = dirty; victim_addr = va; victim_data = vd; fill_addr = fa;
      new_word = 1'b1;
      n = 0;
      while (n < 200) begin
         if (mem_req) begin
            if (new_word) begin
               stall_left = int'($urandom_range(smax, smin));
               h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
               new_word = 1'b0;
            end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wd) begin
               stab_err++;
            end
            if (stall_left > 0) begin
               mem_ack = 1'b0; stall_left--; stall_total++;
            end else begin
               mem_ack = 1'b1;
               tx_we.push_back(mem_we);
               tx_addr.push_back(mem_addr);
               tx_wd.push_back(mem_we ? mem_wdata : '0);
               new_word = 1'b1;
            end
         end else begin
            mem_ack = 1'($urandom_range(0, 1));
         end
         mem_rdata = WORD_W'(mem_addr) ^ key;
         @(posedge clk); #1; n++;
         if (done) begin
            lat = n; got_fill = fill_data;
            break;
         end
         if (toggle && busy) begin
            req = 1'($urandom_range(0, 1)); fill_addr = $urandom; victim_addr = $urandom;
            victim_dirty = 1'($urandom_range(0, 1));
            victim_data = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      if (!keep_req) req = 1'b0;
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
         fails++; $display("FAIL reset_ctrl: busy/done/req/we=%b want 0000", {busy, done, mem_req, mem_we});
      end
      tests++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         fails++; $display("FAIL reset_bus: addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
      end
      tests++;
      if (fill_data !== '0) begin
         fails++; $display("FAIL reset_fill: fill_data=%h want 0", fill_data);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({busy, mem_req} !== 2'b00) begin
         fails++; $display("FAIL idle_no_req: busy/mem_req=%b want 00", {busy, mem_req});
      end
   endtask

   task automatic test_clean_miss();
      int d;
      key = '0;
      build_expect(1'b0, '0, '0, 32'h0000_1234);
      run_line(1'b0, '0, '0, 32'h0000_1234, 0, 0, 1'b0, 1'b0, 1'b1);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL clean_tx[%0d]: got we=%b addr=%h want we=%b addr=%h",
                           d, tx_we[d], tx_addr[d], exp_we[d], exp_addr[d]);
      end
      tests++;
      if (lat != 5) begin fails++; $display("FAIL clean_latency: got %0d want 5", lat); end
      tests++;
      if (got_fill !== {32'h123C, 32'h1238, 32'h1234, 32'h1230}) begin
         fails++; $display("FAIL clean_fill: got %h want 0000123c000012380000123400001230", got_fill);
      end
   endtask

   task automatic test_dirty_miss();
      int d;
      logic [LW-1:0] vd;
      key = $urandom;
      vd = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
      build_expect(1'b1, 32'h40, vd, 32'h80);
      run_line(1'b1, 32'h40, vd, 32'h80, 0, 0, 1'b0, 1'b0, 1'b1);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL dirty_tx[%0d]: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                           d, tx_we[d], tx_addr[d], tx_wd[d], exp_we[d], exp_addr[d], exp_wd[d]);
      end
      tests++;
      if (lat != 9) begin fails++; $display("FAIL dirty_latency: got %0d want 9", lat); end
      tests++;
      if (got_fill !== exp_fill) begin
         fails++; $display("FAIL dirty_fill: got %h want %h", got_fill, exp_fill);
      end
   endtask

   task automatic test_stalls();
      int d;
      key = $urandom;
      build_expect(1'b0, '0, '0, 32'h0000_5678);
      run_line(1'b0, '0, '0, 32'h0000_5678, 3, 3, 1'b0, 1'b0, 1'b1);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL stall_tx[%0d]: got addr=%h want addr=%h", d, tx_addr[d], exp_addr[d]);
      end
      tests++;
      if (lat != 17) begin fails++; $display("FAIL stall_latency: got %0d want 17", lat); end
      tests++;
      if (stab_err != 0) begin fails++; $display("FAIL stall_stable: %0d bus changes during stalls, want 0", stab_err); end
      tests++;
      if (got_fill !== exp_fill) begin fails++; $display("FAIL stall_fill: got %h want %h", got_fill, exp_fill); end
   endtask

   task automatic test_busy_req();
      int d;
      logic [LW-1:0] vd;
      key = $urandom;
      vd = {$urandom, $urandom, $urandom, $urandom};
      build_expect(1'b1, 32'h0000_2A00, vd, 32'h0000_3B08);
      run_line(1'b1, 32'h0000_2A00, vd, 32'h0000_3B08, 0, 1, 1'b1, 1'b0, 1'b1);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL busy_req_tx[%0d]: got we=%b addr=%h want we=%b addr=%h",
                           d, tx_we[d], tx_addr[d], exp_we[d], exp_addr[d]);
      end
      tests++;
      if (lat != exp_lat + stall_total) begin
         fails++; $display("FAIL busy_req_latency: got %0d want %0d", lat, exp_lat + stall_total);
      end
      tests++;
      if (got_fill !== exp_fill) begin fails++; $display("FAIL busy_req_fill: got %h want %h", got_fill, exp_fill); end
   endtask

   task automatic test_back_to_back();
      int d;
      key = $urandom;
      build_expect(1'b0, '0, '0, 32'h0000_0700);
      run_line(1'b0, '0, '0, 32'h0000_0700, 0, 0, 1'b0, 1'b1, 1'b1);
      tests++;
      if (lat != 5) begin fails++; $display("FAIL b2b_first_latency: got %0d want 5", lat); end
      build_expect(1'b0, '0, '0, 32'h0000_0910);
      run_line(1'b0, '0, '0, 32'h0000_0910, 0, 0, 1'b0, 1'b0, 1'b0);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL b2b_second_tx[%0d]: got addr=%h want addr=%h", d, tx_addr[d], exp_addr[d]);
      end
      tests++;
      if (lat != 6) begin fails++; $display("FAIL b2b_second_latency: got %0d want 6", lat); end
      tests++;
      if (got_fill !== exp_fill) begin fails++; $display("FAIL b2b_fill: got %h want %h", got_fill, exp_fill); end
   endtask

   task automatic test_reset_mid_wb();
      int acks, dones, d;
      bit pending;
      logic [LW-1:0] vd;
      acks = 0; dones = 0;
      for (int k = 0; k < 20 && busy; k++) begin @(posedge clk); #1; end
      vd = {$urandom, $urandom, $urandom, $urandom};
      req = 1'b1; victim_dirty = 1'b1; victim_addr = 32'h0000_0100; victim_data = vd;
      fill_addr = 32'h0000_0200; mem_ack = 1'b1;
      for (int k = 0; k < 20 && acks < 2; k++) begin
         pending = mem_req && mem_we;
         @(posedge clk); #1;
         if (pending) acks++;
      end
      tests++;
      if (acks != 2) begin fails++; $display("FAIL rst_wb_acks: got %0d write acks want 2", acks); end
      req = 1'b0;
      rst = 1'b1;
      #1;
      tests++;
      if ({mem_req, busy, done} !== 3'b000) begin
         fails++; $display("FAIL rst_wb_drop: mem_req/busy/done=%b want 000", {mem_req, busy, done});
      end
      tests++;
      if (fill_data !== '0) begin fails++; $display("FAIL rst_wb_fill: got %h want 0", fill_data); end
      @(posedge clk); #2;
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         mem_ack = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (done) dones++;
      end
      mem_ack = 1'b0;
      tests++;
      if (dones != 0 || busy !== 1'b0) begin
         fails++; $display("FAIL rst_wb_no_done: done pulses=%0d busy=%b want 0/0", dones, busy);
      end
      key = $urandom;
      vd = {$urandom, $urandom, $urandom, $urandom};
      build_expect(1'b1, 32'h0000_0104, vd, 32'h0000_020C);
      run_line(1'b1, 32'h0000_0104, vd, 32'h0000_020C, 0, 0, 1'b0, 1'b0, 1'b1);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL rst_wb_restart_tx[%0d]: got addr=%h wd=%h want addr=%h wd=%h",
                           d, tx_addr[d], tx_wd[d], exp_addr[d], exp_wd[d]);
      end
   endtask

   task automatic test_wrap();
      int d;
      key = $urandom;
      build_expect(1'b0, '0, '0, 32'hFFFF_FFF4);
      run_line(1'b0, '0, '0, 32'hFFFF_FFF4, 0, 0, 1'b0, 1'b0, 1'b1);
      d = tx_diff(); tests++;
      if (d != -1) begin
         fails++; $display("FAIL wrap_tx[%0d]: got addr=%h want addr=%h", d, tx_addr[d], exp_addr[d]);
      end
      tests++;
      if (tx_addr.size() != WORDS || tx_addr[WORDS-1] !== 32'hFFFF_FFFC) begin
         fails++; $display("FAIL wrap_last: got %0d words, last addr=%h want 4 / fffffffc",
                           tx_addr.size(), tx_addr[WORDS-1]);
      end
      tests++;
      if (lat != 5) begin fails++; $display("FAIL wrap_latency: got %0d want 5", lat); end
   endtask

   task automatic test_random();
      int d;
      bit dirty;
      logic [ADDR_W-1:0] va, fa;
      logic [LW-1:0] vd;
      for (int it = 0; it < 8; it++) begin
         key = $urandom; dirty = 1'($urandom_range(0, 1));
         va = $urandom; fa = $urandom;
         vd = {$urandom, $urandom, $urandom, $urandom};
         build_expect(dirty, va, vd, fa);
         run_line(dirty, va, vd, fa, 0, 2, 1'b0, 1'b0, 1'b1);
         d = tx_diff(); tests++;
         if (d != -1) begin
            fails++; $display("FAIL rand%0d_tx[%0d]: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                              it, d, tx_we[d], tx_addr[d], tx_wd[d], exp_we[d], exp_addr[d], exp_wd[d]);
         end
         tests++;
         if (lat != exp_lat + stall_total || stab_err != 0) begin
            fails++; $display("FAIL rand%0d_timing: latency %0d stall changes %0d want %0d / 0",
                              it, lat, stab_err, exp_lat + stall_total);
         end
         tests++;
         if (got_fill !== exp_fill) begin
            fails++; $display("FAIL rand%0d_fill: got %h want %h", it, got_fill, exp_fill);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_stalls();
      test_busy_req();
      test_back_to_back();
      test_reset_mid_wb();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
